a_channel_fifo: RTL and testbench
=================================

// Module: a_channel_fifo
// PURPOSE
//  OBI A-channel request buffer between the OBI slave port and the cache controller.
//  Captures read and write requests (addr, we, be, wdata, aid) into a DEPTH-entry FIFO.
//  Drives obi_gnt from FIFO space and the controller's internal_gnt.
//  Presents the oldest request to the controller over a valid/ready handshake.
// PARAMETERS
//  ADDR_WIDTH  32  OBI address width
//  DATA_WIDTH  64  OBI write-data width; must be a multiple of 8
//  ID_WIDTH    4   OBI transaction id (aid) width
//  DEPTH       4   FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1                clock; all state updates on posedge
//  rst_n        in   1                synchronous active-low reset
//  obi_req      in   1                master request valid
//  obi_addr     in   ADDR_WIDTH       request address
//  obi_we       in   1                1=write, 0=read
//  obi_be       in   DATA_WIDTH/8     byte enables
//  obi_wdata    in   DATA_WIDTH       write data; captured for reads too, ignored downstream
//  obi_aid      in   ID_WIDTH         transaction id
//  obi_gnt      out  1                grant to master
//  internal_gnt in   1                controller permits new A-channel acceptance
//  flush        in   1                synchronous clear of all buffered requests
//  cmd_valid    out  1                head entry valid toward controller
//  cmd_ready    in   1                controller consumes head entry
//  cmd_addr     out  ADDR_WIDTH       head entry address
//  cmd_we       out  1                head entry write enable
//  cmd_be       out  DATA_WIDTH/8     head entry byte enables
//  cmd_wdata    out  DATA_WIDTH       head entry write data
//  cmd_aid      out  ID_WIDTH         head entry id
//  count        out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, all storage entries zeroed.
//    Results: cmd_valid=0, cmd_* payload=0, obi_gnt=0 while rst_n=0.
//  - obi_gnt = rst_n && internal_gnt && !flush && (count < DEPTH).
//    Combinational; does not depend on obi_req.
//  - push = obi_req && obi_gnt: entry[wr_ptr] <= {addr,we,be,wdata,aid}; wr_ptr++ (wraps).
//  - pop = cmd_valid && cmd_ready: rd_ptr++ (wraps).
//    cmd_ready while cmd_valid=0 is ignored.
//  - cmd_valid = (count != 0). cmd_* = entry[rd_ptr], combinational read of the head.
//  - Payload is stable while cmd_valid=1 and !pop.
//  - Latency: request accepted at edge N is visible on cmd_* after edge N (cycle N+1).
//    No same-cycle bypass of an empty FIFO.
//  - count update: push&&!pop -> +1; pop&&!push -> -1; both or neither -> unchanged.
//  - Full (count==DEPTH): obi_gnt=0 even if cmd_ready=1 this cycle (no pass-through).
//    Grant returns in the cycle after the pop.
//  - Empty with push and cmd_ready both high: push only; count becomes 1.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally; occupancy comes from count, not pointer compare.
//  - flush=1 at posedge: wr_ptr=rd_ptr=0, count=0. Any push/pop that cycle is discarded.
//    Storage contents are not cleared. obi_gnt=0 during flush.
//  - Reset mid-operation: buffered requests are dropped without a response.
//    Priority at each edge: reset > flush > push/pop.
//  - internal_gnt low stalls acceptance only; draining toward the controller continues.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with obi_req=1 -> obi_gnt=0, cmd_valid=0, count=0, cmd_addr=0.
//  2. Single write: addr=0x100, we=1, be=0xFF, wdata=0xDEADBEEF_CAFEF00D, aid=3, 1 cycle
//     -> next cycle cmd_valid=1 with identical payload; cmd_ready=1 -> count returns to 0.
//  3. Fill: cmd_ready=0, 4 back-to-back reads addr 0x0,0x8,0x10,0x18
//     -> count=4, obi_gnt=0 on 5th cycle; drain yields addrs in order 0x0..0x18.
//  4. Full plus simultaneous pop: count=4 and cmd_ready=1 -> obi_gnt=0 that cycle.
//     Next cycle gnt=1, and a push+pop together keeps count=3 (wrap of wr_ptr checked).
//  5. internal_gnt=0 with obi_req=1 for 3 cycles -> no pushes, count unchanged, existing entries still pop.
//  6. flush with count=2 and obi_req=1 -> obi_gnt=0, next cycle count=0, cmd_valid=0.
//     Next push appears at head.

Source files
------------

// File: rtl/a_channel_fifo.sv
// OBI A-channel request buffer: DEPTH-entry FIFO between the OBI slave port and the cache controller.
// Grant is derived from free space; the head entry is presented on a valid/ready command interface.
module a_channel_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         obi_req,
  input  logic [ADDR_WIDTH-1:0]        obi_addr,
  input  logic                         obi_we,
  input  logic [DATA_WIDTH/8-1:0]      obi_be,
  input  logic [DATA_WIDTH-1:0]        obi_wdata,
  input  logic [ID_WIDTH-1:0]          obi_aid,
  output logic                         obi_gnt,
  input  logic                         internal_gnt,
  input  logic                         flush,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [ADDR_WIDTH-1:0]        cmd_addr,
  output logic                         cmd_we,
  output logic [DATA_WIDTH/8-1:0]      cmd_be,
  output logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic [ID_WIDTH-1:0]          cmd_aid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ID_WIDTH-1:0]     aid;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  entry_t            head;

  // Grant never passes through a full FIFO, even when the head is popping this cycle.
  assign obi_gnt   = rst_n && internal_gnt && !flush && (count_q != FULL_CNT);
  assign cmd_valid = (count_q != '0);
  assign push      = obi_req && obi_gnt;
  assign pop       = cmd_valid && cmd_ready;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_addr  = head.addr;
  assign cmd_we    = head.we;
  assign cmd_be    = head.be;
  assign cmd_wdata = head.wdata;
  assign cmd_aid   = head.aid;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{addr: obi_addr, we: obi_we, be: obi_be,
                            wdata: obi_wdata, aid: obi_aid};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_a_channel_fifo.sv
// Directed bench for a_channel_fifo: hand sequences for reset and single write,
// then a vector table covering fill, full+pop, internal_gnt stall, flush and mid-run reset.
module tb_a_channel_fifo;

  localparam int AW = 32, DW = 64, IW = 4, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, obi_req, obi_we, obi_gnt, internal_gnt, flush;
  logic [AW-1:0] obi_addr, cmd_addr;
  logic [DW/8-1:0] obi_be, cmd_be;
  logic [DW-1:0] obi_wdata, cmd_wdata;
  logic [IW-1:0] obi_aid, cmd_aid;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [2:0]    count;

  int n_tests = 0, n_fail = 0;

  a_channel_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .obi_req(obi_req), .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid), .obi_gnt(obi_gnt),
    .internal_gnt(internal_gnt), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .cmd_aid(cmd_aid), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, req, ig, fl, rdy;
    logic [31:0] addr;
    logic        e_gnt, e_vld;
    logic [2:0]  e_cnt;
    logic [31:0] e_addr;
    logic        chk_addr;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic r, logic q, logic [31:0] a, logic ig, logic fl, logic rdy,
                              logic eg, logic ev, logic [2:0] ec, logic [31:0] ea, logic ca);
    vec_t v;
    v.rst_n = r; v.req = q; v.addr = a; v.ig = ig; v.fl = fl; v.rdy = rdy;
    v.e_gnt = eg; v.e_vld = ev; v.e_cnt = ec; v.e_addr = ea; v.chk_addr = ca;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; obi_req = 1'b1; obi_addr = 32'h55; obi_we = 1'b1; obi_be = 8'hFF;
    obi_wdata = 64'h1; obi_aid = 4'h1; internal_gnt = 1'b1; flush = 1'b0; cmd_ready = 1'b0;

    // Reset held for two edges with a request pending.
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", obi_gnt, 0);
    chk("rst_vld", cmd_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_addr", cmd_addr, 0);

    // Single write: no bypass, visible the cycle after acceptance.
    rst_n = 1'b1; obi_addr = 32'h100; obi_we = 1'b1; obi_be = 8'hFF;
    obi_wdata = 64'hDEADBEEF_CAFEF00D; obi_aid = 4'd3; #1;
    chk("w_gnt", obi_gnt, 1);
    chk("w_nobypass", cmd_valid, 0);
    @(negedge clk); obi_req = 1'b0; #1;
    chk("w_vld", cmd_valid, 1);
    chk("w_cnt", count, 1);
    chk("w_addr", cmd_addr, 32'h100);
    chk("w_we", cmd_we, 1);
    chk("w_be", cmd_be, 8'hFF);
    chk("w_wdata", cmd_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("w_aid", cmd_aid, 3);
    cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0; #1;
    chk("w_drained_cnt", count, 0);
    chk("w_drained_vld", cmd_valid, 0);

    //              rst req addr     ig fl rdy  gnt vld cnt  head     chk
    tbl[0]  = mk(1, 1, 32'h00, 1, 0, 0,  1, 0, 0, 32'h0,  0);   // fill
    tbl[1]  = mk(1, 1, 32'h08, 1, 0, 0,  1, 1, 1, 32'h00, 1);
    tbl[2]  = mk(1, 1, 32'h10, 1, 0, 0,  1, 1, 2, 32'h00, 1);
    tbl[3]  = mk(1, 1, 32'h18, 1, 0, 0,  1, 1, 3, 32'h00, 1);
    tbl[4]  = mk(1, 1, 32'h20, 1, 0, 0,  0, 1, 4, 32'h00, 1);   // full, no grant
    tbl[5]  = mk(1, 1, 32'h20, 1, 0, 1,  0, 1, 4, 32'h00, 1);   // full + pop: still no grant
    tbl[6]  = mk(1, 1, 32'h20, 1, 0, 1,  1, 1, 3, 32'h08, 1);   // push+pop, wr_ptr wraps
    tbl[7]  = mk(1, 0, 32'h00, 1, 0, 1,  1, 1, 3, 32'h10, 1);
    tbl[8]  = mk(1, 1, 32'h40, 0, 0, 1,  0, 1, 2, 32'h18, 1);   // stall, drain continues
    tbl[9]  = mk(1, 1, 32'h40, 0, 0, 0,  0, 1, 1, 32'h20, 1);
    tbl[10] = mk(1, 1, 32'h40, 0, 0, 0,  0, 1, 1, 32'h20, 1);
    tbl[11] = mk(1, 1, 32'h48, 1, 0, 0,  1, 1, 1, 32'h20, 1);
    tbl[12] = mk(1, 1, 32'h50, 1, 1, 1,  0, 1, 2, 32'h20, 1);   // flush
    tbl[13] = mk(1, 1, 32'h58, 1, 0, 1,  1, 0, 0, 32'h0,  0);   // empty push, ready ignored
    tbl[14] = mk(1, 0, 32'h00, 1, 0, 0,  1, 1, 1, 32'h58, 1);
    tbl[15] = mk(1, 0, 32'h00, 1, 0, 1,  1, 1, 1, 32'h58, 1);
    tbl[16] = mk(1, 1, 32'h60, 1, 0, 0,  1, 0, 0, 32'h0,  0);
    tbl[17] = mk(0, 1, 32'h68, 1, 0, 0,  0, 1, 1, 32'h60, 1);   // reset mid-run
    tbl[18] = mk(1, 0, 32'h00, 1, 0, 0,  1, 0, 0, 32'h0,  1);   // storage zeroed

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; obi_req = tbl[i].req; obi_addr = tbl[i].addr; obi_we = 1'b0;
      obi_be = 8'h0F; obi_wdata = {tbl[i].addr, ~tbl[i].addr}; obi_aid = tbl[i].addr[5:2];
      internal_gnt = tbl[i].ig; flush = tbl[i].fl; cmd_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_gnt", i), obi_gnt, tbl[i].e_gnt);
      chk($sformatf("v%0d_vld", i), cmd_valid, tbl[i].e_vld);
      chk($sformatf("v%0d_cnt", i), count, tbl[i].e_cnt);
      if (tbl[i].chk_addr) chk($sformatf("v%0d_addr", i), cmd_addr, tbl[i].e_addr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
